// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave register file: FSM states, synchroniser depth,
// and the position of the read/write flag inside the command word.
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA
    } spi_state_e;

    localparam int SYNC_DEPTH = 2;

    // The R/W flag is always the MSB of the command word.
    function automatic int rw_bit_pos(input int data_w);
        return data_w - 1;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Brings the asynchronous SPI pins into the clk domain and derives SCLK leading/trailing
// pulses and a chip-select falling pulse from one history flop each.
module spi_sync_edge
    import spi_pkg::*;
#(
    parameter bit CPOL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic spi_sclk,
    input  logic spi_cs_n,
    input  logic spi_mosi,
    output logic lead_pulse,
    output logic trail_pulse,
    output logic cs_n_s,
    output logic cs_fall,
    output logic mosi_s
);

    logic [SYNC_DEPTH-1:0] sclk_ff, cs_ff, mosi_ff;
    logic                  sclk_h, cs_h;

    // cs history clears to 0 so a CS already low at reset release is not taken as a new frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_ff <= {SYNC_DEPTH{CPOL}};
            sclk_h  <= CPOL;
            cs_ff   <= '0;
            cs_h    <= 1'b0;
            mosi_ff <= '0;
        end else begin
            sclk_ff <= {sclk_ff[SYNC_DEPTH-2:0], spi_sclk};
            cs_ff   <= {cs_ff[SYNC_DEPTH-2:0], spi_cs_n};
            mosi_ff <= {mosi_ff[SYNC_DEPTH-2:0], spi_mosi};
            sclk_h  <= sclk_ff[SYNC_DEPTH-1];
            cs_h    <= cs_ff[SYNC_DEPTH-1];
        end
    end

    assign lead_pulse  = (sclk_h == CPOL) && (sclk_ff[SYNC_DEPTH-1] != CPOL);
    assign trail_pulse = (sclk_h != CPOL) && (sclk_ff[SYNC_DEPTH-1] == CPOL);
    assign cs_n_s      = cs_ff[SYNC_DEPTH-1];
    assign cs_fall     = cs_h && !cs_ff[SYNC_DEPTH-1];
    assign mosi_s      = mosi_ff[SYNC_DEPTH-1];

endmodule

// File: rtl/spi_slave_regfile.sv
// Oversampled SPI slave: a command word (R/W + address) followed by a burst of data words
// into or out of a small register file, with optional address auto-increment.
module spi_slave_regfile
    import spi_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int N_REGS   = 8,
    parameter int CPOL     = 0,
    parameter int CPHA     = 0,
    parameter int AUTO_INC = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     spi_sclk,
    input  logic                     spi_cs_n,
    input  logic                     spi_mosi,
    output logic                     spi_miso,
    output logic                     spi_miso_oe,
    output logic [N_REGS*DATA_W-1:0] reg_q,
    output logic                     wr_strobe,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic                     busy
);

    localparam bit              CPOL_B   = (CPOL != 0);
    localparam bit              CPHA_B   = (CPHA != 0);
    localparam int              RW_POS   = rw_bit_pos(DATA_W);
    localparam int              CNT_W    = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [ADDR_W:0] N_REGS_V = (ADDR_W + 1)'(N_REGS);

    logic lead_pulse, trail_pulse, cs_n_s, cs_fall, mosi_s;

    spi_sync_edge #(.CPOL(CPOL_B)) u_sync (
        .clk         (clk),
        .rst         (rst),
        .spi_sclk    (spi_sclk),
        .spi_cs_n    (spi_cs_n),
        .spi_mosi    (spi_mosi),
        .lead_pulse  (lead_pulse),
        .trail_pulse (trail_pulse),
        .cs_n_s      (cs_n_s),
        .cs_fall     (cs_fall),
        .mosi_s      (mosi_s)
    );

    spi_state_e                       state;
    logic [CNT_W-1:0]                 bit_cnt;
    logic [DATA_W-1:0]                rx_sh, tx_sh;
    logic                             rw;
    logic [ADDR_W-1:0]                addr;
    logic [N_REGS-1:0][DATA_W-1:0]    regs;

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        if (AUTO_INC == 0) return a;
        if (({1'b0, a} + (ADDR_W + 1)'(1)) >= N_REGS_V) return '0;
        return a + ADDR_W'(1);
    endfunction

    function automatic logic [DATA_W-1:0] rd_word(input logic [N_REGS-1:0][DATA_W-1:0] rf,
                                                   input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] w;
        w = '0;
        for (int i = 0; i < N_REGS; i++)
            if (a == ADDR_W'(i)) w = rf[i];
        return w;
    endfunction

    logic              sample_p, shift_p, word_done, addr_ok;
    logic [DATA_W-1:0] rx_next, ld_word;
    logic [ADDR_W-1:0] ld_addr;

    assign sample_p  = CPHA_B ? trail_pulse : lead_pulse;
    assign shift_p   = CPHA_B ? lead_pulse : trail_pulse;
    assign rx_next   = {rx_sh[DATA_W-2:0], mosi_s};
    assign word_done = sample_p && (bit_cnt == LAST_BIT);
    assign addr_ok   = ({1'b0, addr} < N_REGS_V);
    assign ld_addr   = (state == ST_CMD) ? rx_next[ADDR_W-1:0] : next_addr(addr);
    assign ld_word   = rd_word(regs, ld_addr);
    assign reg_q     = regs;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            rx_sh       <= '0;
            tx_sh       <= '0;
            rw          <= 1'b0;
            addr        <= '0;
            regs        <= '0;
            wr_strobe   <= 1'b0;
            wr_addr     <= '0;
            busy        <= 1'b0;
            spi_miso_oe <= 1'b0;
            spi_miso    <= 1'b0;
        end else begin
            wr_strobe <= 1'b0;
            // CS release takes priority over a word completing on the same clk.
            if (state != ST_IDLE && cs_n_s) begin
                state       <= ST_IDLE;
                bit_cnt     <= '0;
                tx_sh       <= '0;
                busy        <= 1'b0;
                spi_miso_oe <= 1'b0;
                spi_miso    <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (cs_fall) begin
                            state       <= ST_CMD;
                            bit_cnt     <= '0;
                            busy        <= 1'b1;
                            spi_miso_oe <= 1'b1;
                            spi_miso    <= 1'b0;
                        end
                    end
                    default: begin
                        if (sample_p) begin
                            rx_sh   <= rx_next;
                            bit_cnt <= word_done ? '0 : bit_cnt + CNT_W'(1);
                        end
                        if (word_done) begin
                            if (state == ST_CMD) begin
                                state <= ST_DATA;
                                rw    <= rx_next[RW_POS];
                                addr  <= rx_next[ADDR_W-1:0];
                            end else begin
                                if (!rw && addr_ok) begin
                                    for (int i = 0; i < N_REGS; i++)
                                        if (addr == ADDR_W'(i)) regs[i] <= rx_next;
                                    wr_strobe <= 1'b1;
                                    wr_addr   <= addr;
                                end
                                addr <= next_addr(addr);
                            end
                            // Read snapshot: CPHA=0 drives the MSB right away, CPHA=1 waits for the shift edge.
                            if ((state == ST_CMD) ? rx_next[RW_POS] : rw) begin
                                if (!CPHA_B) begin
                                    spi_miso <= ld_word[DATA_W-1];
                                    tx_sh    <= {ld_word[DATA_W-2:0], 1'b0};
                                end else begin
                                    tx_sh <= ld_word;
                                end
                            end
                        end else if (shift_p && state == ST_DATA && rw &&
                                     (CPHA_B || bit_cnt != '0)) begin
                            // With CPHA=0 the shift edge closing a word is skipped: the next MSB is already out.
                            spi_miso <= tx_sh[DATA_W-1];
                            tx_sh    <= {tx_sh[DATA_W-2:0], 1'b0};
                        end
                    end
                endcase
            end
        end
    end

endmodule
